// File: rtl/m_io_pkg.sv
// rtl/m_io_pkg.sv - shared types and constants for the board I/O front end
package m_io_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } deb_state_e;

  localparam int CLK_HZ       = 16_000_000;
  localparam int DEBOUNCE_1MS = 16000;

endpackage

// File: rtl/m_sync2.sv
// rtl/m_sync2.sv - WIDTH-bit two-flop synchroniser into the clk domain
module m_sync2 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/m_sw_debounce.sv
// rtl/m_sw_debounce.sv - switch synchroniser, debouncer, edge strobes and one-deep event register
module m_sw_debounce
  import m_io_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int CNT_W           = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s2;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] sw_state_q;
  logic [WIDTH-1:0] sw_rise_q;
  logic [WIDTH-1:0] sw_fall_q;
  logic [WIDTH-1:0] evt_data_q;
  logic             evt_valid_q;
  logic             evt_overrun_q;
  logic             commit;
  logic             handshake;

  m_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (SW),
    .q_o     (s2)
  );

  // Same priority as the SETTLE branch below: bounce-back, then new value, then window end.
  assign commit    = (state_q == ST_SETTLE) && (s2 != sw_state_q) && (s2 == cand_q) &&
                     (cnt_q == CNT_LAST);
  assign handshake = evt_valid_q & evt_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_STABLE;
      cnt_q         <= '0;
      cand_q        <= '0;
      sw_state_q    <= '0;
      sw_rise_q     <= '0;
      sw_fall_q     <= '0;
      evt_valid_q   <= 1'b0;
      evt_data_q    <= '0;
      evt_overrun_q <= 1'b0;
    end else begin
      sw_rise_q <= '0;
      sw_fall_q <= '0;
      case (state_q)
        ST_STABLE: begin
          if (s2 != sw_state_q) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
            cand_q  <= s2;
          end
        end
        ST_SETTLE: begin
          if (s2 == sw_state_q) begin
            state_q <= ST_STABLE;
          end else if (s2 != cand_q) begin
            cand_q <= s2;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            sw_state_q <= cand_q;
            sw_rise_q  <= cand_q & ~sw_state_q;
            sw_fall_q  <= ~cand_q & sw_state_q;
            state_q    <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_STABLE;
      endcase

      // A commit always wins over a plain handshake; the newer word replaces any pending one.
      if (commit) begin
        evt_data_q  <= cand_q;
        evt_valid_q <= 1'b1;
        if (evt_valid_q && !evt_ready) begin
          evt_overrun_q <= 1'b1;
        end
      end else if (handshake) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign sw_state    = sw_state_q;
  assign sw_rise     = sw_rise_q;
  assign sw_fall     = sw_fall_q;
  assign evt_valid   = evt_valid_q;
  assign evt_data    = evt_data_q;
  assign evt_overrun = evt_overrun_q;

endmodule
